// File: rtl/drfm_pkg.sv
// rtl/drfm_pkg.sv - shared widths, reset gain and scheduler state encoding
package drfm_pkg;

    localparam int DATA_W    = 32;
    localparam int GAIN_W    = 16;
    localparam int FRAC_BITS = 16;
    localparam int CNT_W     = 16;
    localparam logic [GAIN_W-1:0] GAIN_RESET = 16'h8000;

    typedef enum logic [2:0] {
        IDLE,
        MUL_I,
        MUL_Q,
        MUL_SUM,
        STORE
    } state_t;

endpackage

// File: rtl/scaler_scheduler_if.sv
// rtl/scaler_scheduler_if.sv - sample, gain-control and result bundle for the scaler
interface scaler_scheduler_if #(
    parameter int DATA_W = drfm_pkg::DATA_W,
    parameter int GAIN_W = drfm_pkg::GAIN_W,
    parameter int CNT_W  = drfm_pkg::CNT_W
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] i_in;
    logic [DATA_W-1:0] q_in;
    logic [DATA_W-1:0] sum_in;
    logic              gain_wr;
    logic [GAIN_W-1:0] gain_in;
    logic              gain_pending;
    logic [GAIN_W-1:0] active_gain;
    logic              out_valid;
    logic [DATA_W-1:0] i_scaled;
    logic [DATA_W-1:0] q_scaled;
    logic [DATA_W-1:0] sum_scaled;
    logic [CNT_W-1:0]  drop_count;

    modport master (
        output in_valid, i_in, q_in, sum_in, gain_wr, gain_in,
        input  in_ready, gain_pending, active_gain, out_valid,
               i_scaled, q_scaled, sum_scaled, drop_count
    );

    modport slave (
        input  in_valid, i_in, q_in, sum_in, gain_wr, gain_in,
        output in_ready, gain_pending, active_gain, out_valid,
               i_scaled, q_scaled, sum_scaled, drop_count
    );
endinterface

// File: rtl/scaler_scheduler_scale_mult.sv
// rtl/scaler_scheduler_scale_mult.sv - registered unsigned multiplier shared by all channels
module scale_mult #(
    parameter int A_W = drfm_pkg::DATA_W,
    parameter int B_W = drfm_pkg::GAIN_W
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               en,
    input  logic [A_W-1:0]     a,
    input  logic [B_W-1:0]     b,
    output logic [A_W+B_W-1:0] p
);
    always_ff @(posedge clk) begin
        if (clear) begin
            p <= '0;
        end else if (en) begin
            p <= {{B_W{1'b0}}, a} * {{A_W{1'b0}}, b};
        end
    end
endmodule

// File: rtl/scaler_scheduler.sv
// rtl/scaler_scheduler.sv - time-multiplexed gain scaling of I/Q/SUM sample triplets
module scaler_scheduler #(
    parameter int                DATA_W     = drfm_pkg::DATA_W,
    parameter int                GAIN_W     = drfm_pkg::GAIN_W,
    parameter logic [GAIN_W-1:0] GAIN_RESET = drfm_pkg::GAIN_RESET,
    parameter int                CNT_W      = drfm_pkg::CNT_W
) (
    input  logic                M100CLK,
    input  logic                reset,
    scaler_scheduler_if.slave   bus
);
    import drfm_pkg::*;

    localparam int PROD_W = DATA_W + GAIN_W;

    state_t            state, state_next;
    logic [DATA_W-1:0] i_hold, q_hold, sum_hold;
    logic [DATA_W-1:0] i_res, q_res;
    logic [GAIN_W-1:0] op_gain, pend_gain, active_gain;
    logic              gain_pending;
    logic [DATA_W-1:0] i_scaled, q_scaled, sum_scaled;
    logic              out_valid;
    logic [CNT_W-1:0]  drop_count;
    logic [DATA_W-1:0] mult_a;
    logic              mult_en;
    logic [PROD_W-1:0] mult_p;
    logic [DATA_W-1:0] mult_frac;
    logic              idle;
    logic              accept;

    assign idle      = (state == IDLE);
    assign accept    = idle && bus.in_valid;
    assign mult_frac = DATA_W'(mult_p >> FRAC_BITS);

    scale_mult #(
        .A_W (DATA_W),
        .B_W (GAIN_W)
    ) u_mult (
        .clk   (M100CLK),
        .clear (reset),
        .en    (mult_en),
        .a     (mult_a),
        .b     (op_gain),
        .p     (mult_p)
    );

    always_ff @(posedge M100CLK) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mult_a     = '0;
        mult_en    = 1'b0;
        case (state)
            IDLE:    if (bus.in_valid) state_next = MUL_I;
            MUL_I:   begin mult_a = i_hold;   mult_en = 1'b1; state_next = MUL_Q;   end
            MUL_Q:   begin mult_a = q_hold;   mult_en = 1'b1; state_next = MUL_SUM; end
            MUL_SUM: begin mult_a = sum_hold; mult_en = 1'b1; state_next = STORE;   end
            STORE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge M100CLK) begin
        if (reset) begin
            i_hold       <= '0;
            q_hold       <= '0;
            sum_hold     <= '0;
            i_res        <= '0;
            q_res        <= '0;
            op_gain      <= GAIN_RESET;
            pend_gain    <= GAIN_RESET;
            active_gain  <= GAIN_RESET;
            gain_pending <= 1'b0;
            i_scaled     <= '0;
            q_scaled     <= '0;
            sum_scaled   <= '0;
            out_valid    <= 1'b0;
            drop_count   <= '0;
        end else begin
            out_valid <= (state == STORE);

            if (accept) begin
                i_hold   <= bus.i_in;
                q_hold   <= bus.q_in;
                sum_hold <= bus.sum_in;
                // A gain promoted on this same edge must already govern this triplet.
                op_gain  <= gain_pending ? pend_gain : active_gain;
            end

            if (idle && gain_pending) begin
                active_gain  <= pend_gain;
                gain_pending <= 1'b0;
            end
            // A fresh write overrides the clear above so it is never lost.
            if (bus.gain_wr) begin
                pend_gain    <= bus.gain_in;
                gain_pending <= 1'b1;
            end

            if (state == MUL_Q) begin
                i_res <= mult_frac;
            end
            if (state == MUL_SUM) begin
                q_res <= mult_frac;
            end
            if (state == STORE) begin
                i_scaled   <= i_res;
                q_scaled   <= q_res;
                sum_scaled <= mult_frac;
            end

            if (bus.in_valid && !idle && (drop_count != {CNT_W{1'b1}})) begin
                drop_count <= drop_count + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready     = idle;
    assign bus.gain_pending = gain_pending;
    assign bus.active_gain  = active_gain;
    assign bus.out_valid    = out_valid;
    assign bus.i_scaled     = i_scaled;
    assign bus.q_scaled     = q_scaled;
    assign bus.sum_scaled   = sum_scaled;
    assign bus.drop_count   = drop_count;
endmodule

// File: doc/scaler_scheduler.md
Name: scaler_scheduler

Overview:
- Time-multiplexes one registered 32x16 unsigned multiplier across the I, Q and SUM channels of each incoming sample triplet.
- Applies a 16-bit fractional amplitude gain (unsigned Q0.16): result = (x * gain) >> 16.
- Gain updates arrive from the control side and are applied only between triplets, so all three channels of a triplet always use the same gain.
- Sits between the correlator/sum stage and the DRFM output formatter.

Parameters:
- DATA_W, 32, width of i/q/sum in and scaled results out
- GAIN_W, 16, width of gain (all bits fractional)
- GAIN_RESET, 16'h8000, active gain after reset (0.5)
- CNT_W, 16, width of drop counter

Ports:
- M100CLK  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  sample triplet present on i_in/q_in/sum_in
- in_ready  out  1  block can accept a triplet this cycle
- i_in  in  DATA_W  I sample, unsigned
- q_in  in  DATA_W  Q sample, unsigned
- sum_in  in  DATA_W  SUM sample, unsigned
- gain_wr  in  1  one-cycle write strobe for gain_in
- gain_in  in  GAIN_W  new gain value
- gain_pending  out  1  a written gain is waiting to be applied
- active_gain  out  GAIN_W  gain currently in use
- out_valid  out  1  one-cycle pulse: scaled triplet valid
- i_scaled  out  DATA_W  (i*gain)>>16
- q_scaled  out  DATA_W  (q*gain)>>16
- sum_scaled  out  DATA_W  (sum*gain)>>16
- drop_count  out  CNT_W  triplets offered while in_ready=0, saturating

Behaviour:
- Reset (synchronous, sampled every edge, overrides everything including mid-triplet): state=IDLE, in_ready=1, out_valid=0, scaled outputs=0, drop_count=0, gain_pending=0, active_gain=GAIN_RESET, multiplier register=0. A triplet in flight is discarded with no out_valid.
- FSM states: IDLE, MUL_I, MUL_Q, MUL_SUM, STORE. in_ready = (state==IDLE), combinational from state.
- Sequence, with E0 the accept edge (IDLE and in_valid):
  - E0: latch i/q/sum into hold registers; latch active_gain into op_gain; go to MUL_I.
  - E1: mult <= i*op_gain; go to MUL_Q.
  - E2: i_res <= mult>>16; mult <= q*op_gain; go to MUL_SUM.
  - E3: q_res <= mult>>16; mult <= sum*op_gain; go to STORE.
  - E4: i_scaled/q_scaled/sum_scaled updated together; out_valid <= 1; go to IDLE.
- Timing: out_valid is high for exactly the one cycle after E4. Latency is 4 edges; throughput is one triplet per 5 cycles. A new accept is legal at E5 (the cycle out_valid is high).
- Scaled outputs hold their value until the next STORE or reset.
- Arithmetic: full 48-bit product, result = bits [47:16], truncated, no rounding. Since gain < 2^16, the result never overflows DATA_W; no saturation logic.
- Gain handling:
  - gain_wr loads a pending register and sets gain_pending.
  - On any edge with state==IDLE and gain_pending=1: active_gain <= pending, gain_pending <= 0.
  - gain_wr in the same cycle as an accept: that triplet uses the old active_gain; the new value applies from the next triplet.
  - Multiple gain_wr while busy: last value wins.
  - gain_wr while a previous write is still pending: overwrites pending; gain_pending stays 1.
- Drop counting: in_valid=1 with in_ready=0 increments drop_count by 1 per cycle, saturating at all-ones. Dropped data is ignored.

Decomposition:
- Shared package (drfm_pkg): DATA_W, GAIN_W, FRAC_BITS=16, and the state enumeration constants.
- Sub-module scale_mult: registered unsigned DATA_W x GAIN_W multiplier with a synchronous active-high clear on reset. It is the single shared resource, instantiated once.

Test Plan:
- Reset, then i=0x00010000, q=0x00020000, sum=0x00030000, gain 0x8000 -> out_valid one cycle after E4 with 0x00008000 / 0x00010000 / 0x00018000; in_ready low for 4 cycles.
- gain_wr 0xFFFF in the accept cycle of triplet A, then triplet B with the same data -> A scaled by 0x8000, B by 0xFFFF (0x0000FFFF for i=0x00010000); gain_pending cleared at the first IDLE edge.
- Back-to-back in_valid held high for 12 cycles -> exactly 3 accepts (E0, E5, E10), drop_count=9.
- Reset asserted at MUL_Q -> no out_valid; outputs 0; active_gain=0x8000; next triplet processes normally.
- i=0xFFFFFFFF, gain 0xFFFF -> i_scaled=0xFFFEFFFF (truncation, no overflow).
- Hold in_valid while busy for 70000 cycles -> drop_count saturates at 0xFFFF.
